// File: rtl/sine_sample_analyzer.sv
// rtl/sine_sample_analyzer.sv - period and peak analyzer for an offset-binary sine sample stream
module sine_sample_analyzer #(
  parameter int MID      = 128,
  parameter int HYST     = 4,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [7:0]          sample,
  output logic [PERIOD_W-1:0] period,
  output logic [7:0]          amp_max,
  output logic [7:0]          amp_min,
  output logic                meas_valid,
  output logic                locked,
  output logic                overflow
);

  // Thresholds kept at 9 bits so MID +/- HYST never wraps at the code extremes
  localparam logic [8:0]          HI_TH   = 9'(MID + HYST);
  localparam logic [8:0]          LO_TH   = 9'(MID - HYST);
  localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] CNT_MAX = {PERIOD_W{1'b1}};

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    WAIT_LO = 2'd1,
    WAIT_HI = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [7:0]          run_max_q, run_max_d;
  logic [7:0]          run_min_q, run_min_d;
  logic                first_seen_q, first_seen_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [7:0]          amp_max_q, amp_max_d;
  logic [7:0]          amp_min_q, amp_min_d;
  logic                meas_valid_q, meas_valid_d;
  logic                locked_q, locked_d;
  logic                overflow_q, overflow_d;

  logic [8:0]          sample_ext;
  logic                is_hi;
  logic                is_lo;
  logic                crossing;
  logic                count_ev;
  logic                sat;
  logic [PERIOD_W-1:0] cnt_inc;

  assign sample_ext = {1'b0, sample};
  assign is_hi      = (sample_ext >= HI_TH);
  assign is_lo      = (sample_ext <= LO_TH);
  // A rising crossing is an accepted HI sample once the LO side has been seen
  assign crossing   = sample_valid && (state_q == WAIT_HI) && is_hi;
  // Samples between crossings only count once a reference crossing exists
  assign count_ev   = sample_valid && !crossing && first_seen_q;
  assign cnt_inc    = cnt_q + CNT_ONE;
  assign sat        = count_ev && (cnt_inc == CNT_MAX);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ACQUIRE;
    else      state_q <= state_d;
  end

  // Next-state: saturation restarts acquisition, midband samples never move the FSM
  always_comb begin
    state_d = state_q;
    if (sat) begin
      state_d = ACQUIRE;
    end else if (sample_valid) begin
      case (state_q)
        ACQUIRE: state_d = WAIT_LO;
        WAIT_LO: if (is_lo) state_d = WAIT_HI;
        WAIT_HI: if (is_hi) state_d = WAIT_LO;
        default: state_d = ACQUIRE;
      endcase
    end
  end

  // Datapath next values: period counting, running peaks, publish and overflow pulses
  always_comb begin
    cnt_d        = cnt_q;
    run_max_d    = run_max_q;
    run_min_d    = run_min_q;
    first_seen_d = first_seen_q;
    period_d     = period_q;
    amp_max_d    = amp_max_q;
    amp_min_d    = amp_min_q;
    locked_d     = locked_q;
    meas_valid_d = 1'b0;
    overflow_d   = 1'b0;
    if (crossing) begin
      if (first_seen_q) begin
        period_d     = cnt_inc;
        amp_max_d    = run_max_q;
        amp_min_d    = run_min_q;
        meas_valid_d = 1'b1;
        locked_d     = 1'b1;
      end
      cnt_d        = '0;
      run_max_d    = sample;
      run_min_d    = sample;
      first_seen_d = 1'b1;
    end else if (sat) begin
      overflow_d   = 1'b1;
      locked_d     = 1'b0;
      first_seen_d = 1'b0;
      cnt_d        = '0;
    end else if (count_ev) begin
      cnt_d = cnt_inc;
      if (sample > run_max_q) run_max_d = sample;
      if (sample < run_min_q) run_min_d = sample;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      run_max_q    <= 8'h00;
      run_min_q    <= 8'hFF;
      first_seen_q <= 1'b0;
      period_q     <= '0;
      amp_max_q    <= 8'h00;
      amp_min_q    <= 8'hFF;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      run_max_q    <= run_max_d;
      run_min_q    <= run_min_d;
      first_seen_q <= first_seen_d;
      period_q     <= period_d;
      amp_max_q    <= amp_max_d;
      amp_min_q    <= amp_min_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      overflow_q   <= overflow_d;
    end
  end

  assign period     = period_q;
  assign amp_max    = amp_max_q;
  assign amp_min    = amp_min_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_sine_sample_analyzer.sv
// tb/tb_sine_sample_analyzer.sv - directed self-checking bench for sine_sample_analyzer
module tb_sine_sample_analyzer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [7:0]  sample;
  logic [15:0] period;
  logic [7:0]  amp_max;
  logic [7:0]  amp_min;
  logic        meas_valid;
  logic        locked;
  logic        overflow;

  int tests_run    = 0;
  int tests_failed = 0;
  int mv_cnt       = 0;
  int ov_cnt       = 0;
  int both_cnt     = 0;

  sine_sample_analyzer #(.MID(128), .HYST(4), .PERIOD_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .period       (period),
    .amp_max      (amp_max),
    .amp_min      (amp_min),
    .meas_valid   (meas_valid),
    .locked       (locked),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // One clock with the given inputs; outputs are read 1 time unit after the edge
  task automatic step(input logic v, input logic [7:0] s);
    sample_valid = v;
    sample       = s;
    @(posedge clk);
    #1;
    if (meas_valid) mv_cnt++;
    if (overflow) ov_cnt++;
    if (meas_valid && overflow) both_cnt++;
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    sample_valid = 1'b0;
    sample       = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b1;
    mv_cnt   = 0;
    ov_cnt   = 0;
    both_cnt = 0;
  endtask

  // Three square periods plus one HI sample: publishes at samples 41 and 61, leaves cnt=0
  task automatic lock_square();
    for (int n = 0; n < 61; n++) step(1'b1, ((n % 20) < 10) ? 8'd200 : 8'd50);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample_valid = 1'($urandom);
      sample       = 8'($urandom);
      @(posedge clk);
      #1;
    end
    tests_run++; if (period !== 16'd0) begin tests_failed++; $display("FAIL rst_period: got %0d expected 0", period); end
    tests_run++; if (amp_max !== 8'd0) begin tests_failed++; $display("FAIL rst_amp_max: got %0d expected 0", amp_max); end
    tests_run++; if (amp_min !== 8'd255) begin tests_failed++; $display("FAIL rst_amp_min: got %0d expected 255", amp_min); end
    tests_run++; if (meas_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_meas_valid: got %0b expected 0", meas_valid); end
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL rst_locked: got %0b expected 0", locked); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL rst_overflow: got %0b expected 0", overflow); end
    rst = 1'b1;
    mv_cnt = 0; ov_cnt = 0; both_cnt = 0;
    // acquire, arm, first crossing (publishes nothing), re-arm
    step(1'b1, 8'd128);
    step(1'b1, 8'd50);
    step(1'b1, 8'd200);
    step(1'b1, 8'd50);
    tests_run++; if (mv_cnt !== 0) begin tests_failed++; $display("FAIL rel_no_publish: got %0d expected 0", mv_cnt); end
    tests_run++; if (period !== 16'd0) begin tests_failed++; $display("FAIL rel_period_hold: got %0d expected 0", period); end
    tests_run++; if (amp_max !== 8'd0 || amp_min !== 8'd255) begin tests_failed++; $display("FAIL rel_amp_hold: got %0d/%0d expected 0/255", amp_max, amp_min); end
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL rel_locked: got %0b expected 0", locked); end
  endtask

  task automatic test_square();
    int idx, last, first, pulses;
    do_reset();
    idx = 0; last = -1; first = -1; pulses = 0;
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 20; i++) begin
        step(1'b1, (i < 10) ? 8'd200 : 8'd50);
        idx++;
        if (idx == 21) begin
          tests_run++; if (meas_valid !== 1'b0 || locked !== 1'b0) begin tests_failed++; $display("FAIL sq_first_cross: got mv=%0b lk=%0b expected 0/0", meas_valid, locked); end
        end
        if (meas_valid) begin
          pulses++;
          if (first < 0) first = idx;
          tests_run++; if (period !== 16'd20) begin tests_failed++; $display("FAIL sq_period: got %0d expected 20", period); end
          tests_run++; if (amp_max !== 8'd200 || amp_min !== 8'd50) begin tests_failed++; $display("FAIL sq_amp: got %0d/%0d expected 200/50", amp_max, amp_min); end
          tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL sq_locked: got %0b expected 1", locked); end
          if (last >= 0) begin
            tests_run++; if (idx - last !== 20) begin tests_failed++; $display("FAIL sq_spacing: got %0d expected 20", idx - last); end
          end
          last = idx;
        end
      end
    end
    tests_run++; if (first !== 41) begin tests_failed++; $display("FAIL sq_first_pulse: got %0d expected 41", first); end
    tests_run++; if (pulses !== 3) begin tests_failed++; $display("FAIL sq_pulses: got %0d expected 3", pulses); end
  endtask

  task automatic test_sine();
    logic [7:0] dds [256];
    int pulses;
    for (int k = 0; k < 256; k++)
      dds[k] = 8'(int'(128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 256.0)));
    do_reset();
    pulses = 0;
    for (int n = 0; n < 1024; n++) begin
      step(1'b1, dds[n % 256]);
      if (meas_valid) begin
        pulses++;
        tests_run++; if (period !== 16'd256) begin tests_failed++; $display("FAIL sine_period: got %0d expected 256", period); end
        tests_run++; if (amp_max !== 8'd255 || amp_min !== 8'd1) begin tests_failed++; $display("FAIL sine_amp: got %0d/%0d expected 255/1", amp_max, amp_min); end
      end
    end
    tests_run++; if (pulses !== 2) begin tests_failed++; $display("FAIL sine_pulses: got %0d expected 2", pulses); end
  endtask

  task automatic test_gaps();
    int c, n, pulses;
    do_reset();
    c = 0; n = 0; pulses = 0;
    while (n < 100) begin
      if (c % 3 == 2) begin
        step(1'b0, 8'd0);
      end else begin
        step(1'b1, ((n % 20) < 10) ? 8'd200 : 8'd50);
        n++;
      end
      c++;
      if (meas_valid) begin
        pulses++;
        tests_run++; if (period !== 16'd20) begin tests_failed++; $display("FAIL gap_period: got %0d expected 20", period); end
        tests_run++; if (amp_max !== 8'd200 || amp_min !== 8'd50) begin tests_failed++; $display("FAIL gap_amp: got %0d/%0d expected 200/50", amp_max, amp_min); end
      end
    end
    tests_run++; if (pulses !== 3) begin tests_failed++; $display("FAIL gap_pulses: got %0d expected 3", pulses); end
  endtask

  task automatic test_hysteresis();
    int base;
    do_reset();
    lock_square();
    base = mv_cnt;
    for (int i = 0; i < 500; i++) begin
      step(1'b1, 8'd126);
      step(1'b1, 8'd130);
    end
    tests_run++; if (mv_cnt !== base) begin tests_failed++; $display("FAIL hyst_no_pulse: got %0d expected %0d", mv_cnt, base); end
    tests_run++; if (period !== 16'd20 || locked !== 1'b1) begin tests_failed++; $display("FAIL hyst_hold: got p=%0d lk=%0b expected 20/1", period, locked); end
    step(1'b1, 8'd124);
    tests_run++; if (meas_valid !== 1'b0) begin tests_failed++; $display("FAIL hyst_lo_edge: got %0b expected 0", meas_valid); end
    step(1'b1, 8'd132);
    tests_run++; if (meas_valid !== 1'b1) begin tests_failed++; $display("FAIL hyst_hi_edge: got %0b expected 1", meas_valid); end
    tests_run++; if (period !== 16'd1002) begin tests_failed++; $display("FAIL hyst_period: got %0d expected 1002", period); end
    tests_run++; if (amp_max !== 8'd200 || amp_min !== 8'd124) begin tests_failed++; $display("FAIL hyst_amp: got %0d/%0d expected 200/124", amp_max, amp_min); end
    step(1'b1, 8'd128);
    tests_run++; if (mv_cnt !== base + 1 || meas_valid !== 1'b0) begin tests_failed++; $display("FAIL hyst_single: got %0d expected %0d", mv_cnt, base + 1); end
  endtask

  task automatic test_midreset();
    do_reset();
    lock_square();
    repeat (5) step(1'b1, 8'd200);
    rst = 1'b0;
    #2;
    tests_run++; if (period !== 16'd0 || locked !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_async: got p=%0d lk=%0b expected 0/0", period, locked); end
    tests_run++; if (amp_max !== 8'd0 || amp_min !== 8'd255) begin tests_failed++; $display("FAIL mid_rst_amp: got %0d/%0d expected 0/255", amp_max, amp_min); end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_overflow();
    do_reset();
    lock_square();
    for (int j = 1; j <= 65535; j++) step(1'b1, 8'd128);
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_pulse: got %0b expected 1", overflow); end
    tests_run++; if (ov_cnt !== 1) begin tests_failed++; $display("FAIL ovf_count: got %0d expected 1", ov_cnt); end
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL ovf_locked: got %0b expected 0", locked); end
    tests_run++; if (period !== 16'd20 || mv_cnt !== 2) begin tests_failed++; $display("FAIL ovf_hold: got p=%0d mv=%0d expected 20/2", period, mv_cnt); end
    step(1'b1, 8'd128);
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_one_cycle: got %0b expected 0", overflow); end
    repeat (5) step(1'b1, 8'd50);
    step(1'b1, 8'd200);
    tests_run++; if (meas_valid !== 1'b0) begin tests_failed++; $display("FAIL ovf_first_cross: got %0b expected 0", meas_valid); end
    repeat (4) step(1'b1, 8'd200);
    repeat (5) step(1'b1, 8'd50);
    step(1'b1, 8'd200);
    tests_run++; if (meas_valid !== 1'b1 || period !== 16'd10) begin tests_failed++; $display("FAIL ovf_relock: got mv=%0b p=%0d expected 1/10", meas_valid, period); end
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL ovf_relocked: got %0b expected 1", locked); end
    tests_run++; if (both_cnt !== 0) begin tests_failed++; $display("FAIL mv_ovf_exclusive: got %0d expected 0", both_cnt); end
  endtask

  initial begin
    rst          = 1'b0;
    sample_valid = 1'b0;
    sample       = 8'd0;
    test_reset();
    test_square();
    test_sine();
    test_gaps();
    test_hysteresis();
    test_midreset();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
